// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_e;

    // Byte-within-word bits (words are always 32 bits wide).
    localparam int BYTE_BITS = 2;
    // Widest address the field helpers accept.
    localparam int ADDR_MAX = 64;

    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_lines, input int words_per_line);
        return addr_width - BYTE_BITS - off_bits(words_per_line) - idx_bits(num_lines);
    endfunction

    // Word offset within the line.
    function automatic logic [ADDR_MAX-1:0] addr_offset(input logic [ADDR_MAX-1:0] addr,
                                                        input int words_per_line);
        return (addr >> BYTE_BITS) & ADDR_MAX'(words_per_line - 1);
    endfunction

    // Line index.
    function automatic logic [ADDR_MAX-1:0] addr_index(input logic [ADDR_MAX-1:0] addr,
                                                       input int num_lines,
                                                       input int words_per_line);
        return (addr >> (BYTE_BITS + off_bits(words_per_line))) & ADDR_MAX'(num_lines - 1);
    endfunction

    // Tag: everything above the index.
    function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] addr,
                                                     input int num_lines,
                                                     input int words_per_line);
        return addr >> (BYTE_BITS + off_bits(words_per_line) + idx_bits(num_lines));
    endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
// master = fetch stage plus backing memory, slave = the cache.
interface icache_direct_mapped_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  stall;
    logic                  invalidate;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_address;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output read_enable, read_address, invalidate,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  read_data, read_valid, stall,
        input  mem_req_valid, mem_req_address
    );

    modport slave (
        input  read_enable, read_address, invalidate,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output read_data, read_valid, stall,
        output mem_req_valid, mem_req_address
    );
endinterface

// File: rtl/icache_data_array.sv
// Instruction word storage: one write port for refill beats, one registered read port.
module icache_data_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Refill beat write.
    // NOTE: storage arrays are never reset; the valid bits alone decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; output holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: tag/valid lookup, refill FSM, whole-cache invalidate.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic clk,
    input  logic reset_n,
    icache_direct_mapped_if.slave bus
);
    localparam int OFF_W  = off_bits(WORDS_PER_LINE);
    localparam int IDX_W  = idx_bits(NUM_LINES);
    localparam int TAG_W  = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam int LOW_W  = BYTE_BITS + OFF_W;
    localparam int DADR_W = IDX_W + OFF_W;

    state_e                 state_q, state_d;
    logic [OFF_W-1:0]       beat_q, beat_d;
    logic                   inval_pending_q, inval_pending_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic                   read_valid_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];

    logic [ADDR_MAX-1:0]    rd_addr_ext, fill_addr_ext;
    logic [IDX_W-1:0]       rd_idx, fill_idx;
    logic [OFF_W-1:0]       rd_off;
    logic [TAG_W-1:0]       rd_tag, fill_tag;
    logic [ADDR_WIDTH-1:0]  line_base;
    logic                   hit;

    logic                   clear_all, clear_line, fill_done, fill_we, rd_en;

    // Field extraction for the fetch address and the line being refilled.
    assign rd_addr_ext   = ADDR_MAX'(bus.read_address);
    assign fill_addr_ext = ADDR_MAX'(req_addr_q);
    assign rd_idx        = IDX_W'(addr_index(rd_addr_ext, NUM_LINES, WORDS_PER_LINE));
    assign rd_off        = OFF_W'(addr_offset(rd_addr_ext, WORDS_PER_LINE));
    assign rd_tag        = TAG_W'(addr_tag(rd_addr_ext, NUM_LINES, WORDS_PER_LINE));
    assign fill_idx      = IDX_W'(addr_index(fill_addr_ext, NUM_LINES, WORDS_PER_LINE));
    assign fill_tag      = TAG_W'(addr_tag(fill_addr_ext, NUM_LINES, WORDS_PER_LINE));
    assign line_base     = {bus.read_address[ADDR_WIDTH-1:LOW_W], {LOW_W{1'b0}}};

    assign hit = bus.read_enable && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign bus.stall           = (state_q != IDLE) || (bus.read_enable && !hit) || bus.invalidate;
    assign bus.mem_req_valid   = (state_q == REQ);
    assign bus.mem_req_address = req_addr_q;
    assign bus.read_valid      = read_valid_q;

    // Next-state and control decode for lookup, request and line fill.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d         = state_q;
        beat_d          = beat_q;
        inval_pending_d = inval_pending_q;
        req_addr_d      = req_addr_q;
        clear_all       = 1'b0;
        clear_line      = 1'b0;
        fill_done       = 1'b0;
        fill_we         = 1'b0;
        rd_en           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.invalidate) begin
                    clear_all = 1'b1;
                end else if (hit) begin
                    rd_en = 1'b1;
                end else if (bus.read_enable) begin
                    // Victim line goes invalid now so a partial fill can never hit.
                    req_addr_d = line_base;
                    clear_line = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.invalidate) begin
                    inval_pending_d = 1'b1;
                end
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.invalidate) begin
                    inval_pending_d = 1'b1;
                end
                if (bus.mem_resp_valid) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        // An invalidate seen during the refill also wipes the new line.
                        fill_done       = 1'b1;
                        clear_all       = inval_pending_q || bus.invalidate;
                        inval_pending_d = 1'b0;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, refill bookkeeping, valid bits and read_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            inval_pending_q <= 1'b0;
            req_addr_q      <= '0;
            read_valid_q    <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            inval_pending_q <= inval_pending_d;
            req_addr_q      <= req_addr_d;
            read_valid_q    <= rd_en;
            if (clear_all) begin
                valid_q <= '0;
            end else if (clear_line) begin
                valid_q[rd_idx] <= 1'b0;
            end else if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag capture when a line completes.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    icache_data_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (DADR_W)
    ) u_data (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (fill_we),
        .waddr   ({fill_idx, beat_q}),
        .wdata   (bus.mem_resp_data),
        .re      (rd_en),
        .raddr   ({rd_idx, rd_off}),
        .rdata   (bus.read_data)
    );
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, line-based instruction cache between the fetch stage and a word-wide backing instruction memory.
- Hits return one word per cycle with one-cycle registered latency.
- Misses stall fetch while a refill state machine bursts a full line from backing memory.
- Adds tags, valid bits, miss handling and whole-cache invalidate (fence.i) on top of the plain preloaded instruction store.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, instruction/memory word width; must be 32.
- NUM_LINES, 16, cache lines; power of two, >= 2.
- WORDS_PER_LINE, 4, words per line; power of two, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- read_enable  in  1  fetch request valid.
- read_address  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- read_data  out  DATA_WIDTH  fetched word, registered.
- read_valid  out  1  read_data valid this cycle.
- stall  out  1  combinational; fetch must hold read_enable/read_address while high.
- invalidate  in  1  one-cycle pulse: clear all valid bits.
- mem_req_valid  out  1  refill request.
- mem_req_address  out  ADDR_WIDTH  line-aligned refill base address.
- mem_req_ready  in  1  backing memory accepts request.
- mem_resp_valid  in  1  refill beat valid.
- mem_resp_data  in  DATA_WIDTH  refill beat, words in ascending address order.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Address split, LSB first:
  - 2 byte bits (ignored).
  - OFF = log2(WORDS_PER_LINE) word-offset bits.
  - IDX = log2(NUM_LINES) index bits.
  - Tag = remaining upper bits.
- Storage:
  - Valid and tag arrays are flops with combinational lookup.
  - Data array is written per word and read with registered output.
- Reset values:
  - All valid bits 0; state IDLE.
  - read_valid 0, read_data 0, mem_req_valid 0, mem_req_address 0.
  - Beat counter 0; invalidate_pending 0.
- Hit = read_enable && valid[idx] && tag[idx]==addr_tag.
- stall = (state!=IDLE) || (read_enable && !hit) || invalidate.
- State IDLE:
  - Hit, no invalidate: next cycle read_valid=1 and read_data=line[idx][off]. Back-to-back hits give 1 word/cycle.
  - read_enable low: read_valid=0 next cycle; read_data holds its last value.
  - Miss: latch line address. Next cycle go to REQ.
  - invalidate (with or without read_enable): clear all valid bits next cycle. No read_valid. Any held read is re-evaluated next cycle and misses.
- State REQ:
  - mem_req_valid=1, mem_req_address = {tag,idx,0...}.
  - On mem_req_ready go to FILL and clear the beat counter.
  - mem_req_valid stays high until accepted.
- State FILL:
  - Each mem_resp_valid writes mem_resp_data into word[beat] and increments beat.
  - Gaps between beats are allowed.
  - The valid bit for the line is cleared at REQ entry, so a partially filled line never hits.
  - After beat WORDS_PER_LINE-1: write the tag, set valid (unless invalidate_pending), go to IDLE.
  - The held request then hits.
  - Miss penalty = 1 + request wait + WORDS_PER_LINE beats + 1 cycles before read_valid.
- Invalidate outside IDLE:
  - Sets invalidate_pending.
  - On FILL completion all valid bits are cleared, including the just-filled line. The held request re-misses.
- Conflict: a miss replaces the indexed line unconditionally (no dirty state, read-only).
- Ignored inputs: mem_resp_valid in IDLE/REQ and mem_req_ready outside REQ are ignored.
- Reset mid-refill:
  - Abandons the refill; mem_req_valid drops in the next cycle.
  - Late responses are ignored; no line is left valid.
  - The backing memory must itself be reset alongside.
- Beat counter width is OFF bits; it wraps to 0 exactly at the end of the line.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, REQ, FILL}.
  - localparam functions for OFF/IDX/tag widths.
  - address-field extraction functions.
- One sub-module, icache_data_array: NUM_LINES*WORDS_PER_LINE words, single write port, registered read port.
- Tags, valid bits and the FSM stay in the top module.

Test Plan:
- Cold miss, defaults: fetch 0x40; memory answers ready after 1 cycle with beats 0xA0..0xA3.
  -> mem_req_address=0x40; stall high 7 cycles; read_data=0xA0, read_valid=1.
- Hits after fill: fetch 0x44, 0x48, 0x4C on consecutive cycles.
  -> read_valid each cycle with 0xA1, 0xA2, 0xA3; no mem_req_valid.
- Conflict eviction: fill 0x40, then fetch 0x140 (same index, new tag), then 0x40.
  -> two refills with mem_req_address 0x140 then 0x40; correct data each time.
- Backpressure and beat gaps: mem_req_ready low 3 cycles, one idle cycle between beats 1 and 2.
  -> mem_req_valid held stable with a stable address; data correct; stall held throughout.
- Invalidate: invalidate pulse during FILL of 0x40.
  -> refill completes; next fetch of 0x40 triggers a second mem_req. Invalidate in IDLE after a hit forces a miss on the next fetch.
- Reset mid-refill: reset_n low for one cycle during beat 2.
  -> all outputs 0 next cycle; stray beats ignored; fetch 0x40 afterwards issues a fresh request.
